// File: rtl/dpe_pkg.sv
// Shared types and size helpers for the dot-product engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2
    } dpe_state_e;

    // Number of result bytes streamed out for a given accumulator width.
    function automatic int byte_count(input int acc_w);
        return acc_w / 8;
    endfunction

    // Index width for a counter covering n positions (never narrower than 1).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ACC_W  = 24;
    localparam int DEF_NBYTES = byte_count(DEF_ACC_W);
    localparam int DEF_BIDX_W = idx_width(DEF_NBYTES);

endpackage

// File: rtl/dpe_shift_bank.sv
// Operand bank: shift register of LANES elements, new element enters lane 0.
// Latency: 1 cycle from shift_en to visible on par_out.
// Backpressure: none; the caller gates shift_en.
module dpe_shift_bank #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          shift_en,
    input  logic [ELEM_W-1:0]             din,
    output logic [LANES-1:0][ELEM_W-1:0]  par_out
);

    logic [LANES-1:0][ELEM_W-1:0] bank_q, bank_d;

    // Next bank contents: every lane moves up one, din lands in lane 0.
    always_comb begin
        bank_d = bank_q;
        if (shift_en) begin
            for (int i = LANES - 1; i > 0; i--) begin
                bank_d[i] = bank_q[i-1];
            end
            bank_d[0] = din;
        end
    end

    // Bank storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bank_q <= '0;
        else     bank_q <= bank_d;
    end

    assign par_out = bank_q;

endmodule

// File: rtl/dot_product_engine.sv
// Dot product of two LANES-wide operand banks into a wrapping accumulator.
// Latency: LANES MAC cycles after start, then ACC_W/8 bytes LSB first.
// Backpressure: each result byte holds until out_ready; load/start only in IDLE.
module dot_product_engine
    import dpe_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int ELEM_W = 7,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    input  logic              acc_clear,
    input  logic              signed_mode,
    output logic              busy,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int NBYTES = byte_count(ACC_W);
    localparam int BIDX_W = idx_width(NBYTES);
    localparam int LIDX_W = idx_width(LANES);

    dpe_state_e                   state_q, state_d;
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic [LIDX_W-1:0]            lane_q, lane_d;
    logic [BIDX_W-1:0]            byte_q, byte_d;
    logic                         clear_q, clear_d;
    logic                         signed_q, signed_d;

    logic [LANES-1:0][ELEM_W-1:0] data_bank, wt_bank;
    logic                         load_fire;
    logic [ACC_W-1:0]             op_a, op_b, acc_base;
    logic [7:0]                   byte_sel;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_MAC) || (state_q == ST_DRAIN);
    assign out_valid = (state_q == ST_DRAIN);
    assign out_byte  = out_valid ? byte_sel : 8'h00;
    assign load_fire = in_valid && in_ready;

    dpe_shift_bank #(.LANES(LANES), .ELEM_W(ELEM_W)) u_data_bank (
        .clk      (clk),
        .rst      (rst),
        .shift_en (load_fire && !in_sel),
        .din      (in_data),
        .par_out  (data_bank)
    );

    dpe_shift_bank #(.LANES(LANES), .ELEM_W(ELEM_W)) u_wt_bank (
        .clk      (clk),
        .rst      (rst),
        .shift_en (load_fire && in_sel),
        .din      (in_data),
        .par_out  (wt_bank)
    );

    // Extend the current lane's operands to accumulator width by mode.
    always_comb begin
        op_a = {{(ACC_W-ELEM_W){signed_q & data_bank[lane_q][ELEM_W-1]}}, data_bank[lane_q]};
        op_b = {{(ACC_W-ELEM_W){signed_q & wt_bank[lane_q][ELEM_W-1]}},   wt_bank[lane_q]};
    end

    // Pick the result byte addressed by the drain index.
    always_comb begin
        byte_sel = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (byte_q == BIDX_W'(b)) byte_sel = acc_q[b*8 +: 8];
        end
    end

    // Sequencing: IDLE -> MAC (LANES lanes) -> DRAIN (NBYTES bytes) -> IDLE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        lane_d   = lane_q;
        byte_d   = byte_q;
        clear_d  = clear_q;
        signed_d = signed_q;
        // A clear run must not pick up the old result even on lane 0.
        acc_base = (clear_q && lane_q == '0) ? '0 : acc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_MAC;
                    clear_d  = acc_clear;
                    signed_d = signed_mode;
                    lane_d   = '0;
                    byte_d   = '0;
                    if (acc_clear) acc_d = '0;
                end
            end
            ST_MAC: begin
                acc_d = acc_base + op_a * op_b;
                if (lane_q == LIDX_W'(LANES - 1)) begin
                    state_d = ST_DRAIN;
                    lane_d  = '0;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (byte_q == BIDX_W'(NBYTES - 1)) begin
                        state_d = ST_IDLE;
                        byte_d  = '0;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            lane_q   <= '0;
            byte_q   <= '0;
            clear_q  <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            lane_q   <= lane_d;
            byte_q   <= byte_d;
            clear_q  <= clear_d;
            signed_q <= signed_d;
        end
    end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine with a byte scoreboard and a reference model.
// Latency: n/a.
// Backpressure: exercises out_ready stalls.
module tb_dot_product_engine;

    localparam int LANES  = 4;
    localparam int ELEM_W = 7;
    localparam int ACC_W  = 24;
    localparam int NBYTES = ACC_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [ELEM_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic              start;
    logic              acc_clear;
    logic              signed_mode;
    logic              busy;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;

    dot_product_engine #(.LANES(LANES), .ELEM_W(ELEM_W), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .start       (start),
        .acc_clear   (acc_clear),
        .signed_mode (signed_mode),
        .busy        (busy),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [ELEM_W-1:0] m_data [LANES];
    logic [ELEM_W-1:0] m_wt   [LANES];
    logic [ACC_W-1:0]  m_acc;
    logic [7:0]        sb_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_shift(input logic sel, input logic [ELEM_W-1:0] v);
        if (!sel) begin
            for (int i = LANES - 1; i > 0; i--) m_data[i] = m_data[i-1];
            m_data[0] = v;
        end else begin
            for (int i = LANES - 1; i > 0; i--) m_wt[i] = m_wt[i-1];
            m_wt[0] = v;
        end
    endtask

    function automatic int elem_val(input logic [ELEM_W-1:0] v, input logic sgn);
        return (sgn && v[ELEM_W-1]) ? int'(v) - (1 << ELEM_W) : int'(v);
    endfunction

    // Compute the expected result and queue its bytes, LSB first.
    task automatic model_run(input logic clr, input logic sgn);
        if (clr) m_acc = '0;
        for (int i = 0; i < LANES; i++) begin
            m_acc = m_acc + ACC_W'(elem_val(m_data[i], sgn) * elem_val(m_wt[i], sgn));
        end
        for (int b = 0; b < NBYTES; b++) sb_q.push_back(m_acc[b*8 +: 8]);
    endtask

    task automatic load(input logic sel, input logic [ELEM_W-1:0] v);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = v;
        model_shift(sel, v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic load_vec(input logic sel, input int a, input int b, input int c, input int d);
        load(sel, ELEM_W'(a));
        load(sel, ELEM_W'(b));
        load(sel, ELEM_W'(c));
        load(sel, ELEM_W'(d));
    endtask

    task automatic kick(input logic clr, input logic sgn);
        model_run(clr, sgn);
        start       = 1'b1;
        acc_clear   = clr;
        signed_mode = sgn;
        step();
        start       = 1'b0;
        acc_clear   = 1'b0;
        signed_mode = 1'b0;
        chk("mac_busy", 32'(busy), 32'd1);
        chk("mac_in_ready", 32'(in_ready), 32'd0);
        chk("mac_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        logic [7:0] exp_b;
        out_ready = 1'b1;
        for (int b = 0; b < NBYTES; b++) begin
            wait_valid({tag, "_valid"});
            exp_b = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
            chk({tag, "_byte"}, 32'(out_byte), 32'(exp_b));
            step();
        end
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
        chk({tag, "_not_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
        start = 1'b0; acc_clear = 1'b0; signed_mode = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < LANES; i++) begin m_data[i] = '0; m_wt[i] = '0; end
        m_acc = '0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Reset state.
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_byte", 32'(out_byte), 32'd0);

        // Unsigned run: 1..4 . 5..8 = 70.
        load_vec(1'b0, 1, 2, 3, 4);
        load_vec(1'b1, 5, 6, 7, 8);
        kick(1'b1, 1'b0);
        drain("unsigned");

        // Chained accumulate: 140.
        kick(1'b0, 1'b0);
        drain("accum");

        // Backpressure on the first byte.
        kick(1'b1, 1'b0);
        out_ready = 1'b0;
        wait_valid("bp_valid");
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_byte", 32'(out_byte), 32'h46);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        drain("bp");

        // Signed run: all -1 times 3 = -12.
        load_vec(1'b0, 'h7F, 'h7F, 'h7F, 'h7F);
        load_vec(1'b1, 3, 3, 3, 3);
        kick(1'b1, 1'b1);
        drain("signed");

        // Unsigned chained onto -12: wraps through 2^24 to 58.
        load_vec(1'b0, 1, 2, 3, 4);
        load_vec(1'b1, 5, 6, 7, 8);
        kick(1'b0, 1'b0);
        drain("wrap");

        // Busy rejection: start and loads during MAC leave the run untouched.
        kick(1'b1, 1'b0);
        start = 1'b1; acc_clear = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 7'd99;
        repeat (2) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        start = 1'b0; in_valid = 1'b0;
        drain("busy_reject");

        // Load and start in the same IDLE cycle: MAC sees the new element.
        load(1'b0, 7'd9);
        load(1'b0, 7'd10);
        load(1'b0, 7'd11);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 7'd12;
        model_shift(1'b0, 7'd12);
        kick(1'b1, 1'b0);
        in_valid = 1'b0;
        drain("load_and_start");

        // Reset during MAC cycle 2, then a fresh run.
        kick(1'b1, 1'b0);
        step();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        sb_q.delete();
        for (int i = 0; i < LANES; i++) begin m_data[i] = '0; m_wt[i] = '0; end
        m_acc = '0;
        step();
        rst = 1'b0;
        step();
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        load_vec(1'b0, 1, 2, 3, 4);
        load_vec(1'b1, 5, 6, 7, 8);
        kick(1'b1, 1'b0);
        drain("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
